// File: rtl/qed_commit_if.sv
// Commit-stream and status bundle between a core's architectural commit ports
// and the QED commit checker.
interface qed_commit_if #(
  parameter int DATA_LEN = 32,
  parameter int REG_SEL  = 5,
  parameter int CNT_W    = 16
);
  logic                ena;
  logic                arfwe1;
  logic                arfwe2;
  logic [REG_SEL-1:0]  dstarf1;
  logic [REG_SEL-1:0]  dstarf2;
  logic [DATA_LEN-1:0] wdata1;
  logic [DATA_LEN-1:0] wdata2;
  logic [CNT_W-1:0]    orig_cnt;
  logic [CNT_W-1:0]    dup_cnt;
  logic                busy;
  logic                check_done;
  logic                check_pass;
  logic                qed_fail;
  logic [3:0]          fail_idx;

  modport master (
    output ena, arfwe1, arfwe2, dstarf1, dstarf2, wdata1, wdata2,
    input  orig_cnt, dup_cnt, busy, check_done, check_pass, qed_fail, fail_idx
  );

  modport slave (
    input  ena, arfwe1, arfwe2, dstarf1, dstarf2, wdata1, wdata2,
    output orig_cnt, dup_cnt, busy, check_done, check_pass, qed_fail, fail_idx
  );
endinterface

// File: rtl/qed_commit_checker.sv
// Shadows the dual-port commit stream and, once original and duplicate commit
// counts agree, sweeps r1..r15 against r17..r31 and flags the first mismatch.
module qed_commit_checker #(
  parameter int DATA_LEN = 32,
  parameter int REG_SEL  = 5,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  qed_commit_if.slave cif
);
  localparam int                 NREG    = 1 << REG_SEL;
  localparam logic [REG_SEL-1:0] DUP_OFS = REG_SEL'(16);

  typedef enum logic {S_IDLE, S_CHECK} state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic                dirty_q, dirty_d;
  logic [CNT_W-1:0]    orig_q, orig_d;
  logic [CNT_W-1:0]    dup_q, dup_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [3:0]          fail_idx_q, fail_idx_d;
  logic [DATA_LEN-1:0] shadow_q [NREG];
  logic [DATA_LEN-1:0] shadow_d [NREG];

  logic               commit;
  logic               o1, o2, u1, u2;
  logic [REG_SEL-1:0] orig_sel, dup_sel;
  logic               pair_match;

  function automatic logic is_orig(input logic [REG_SEL-1:0] dst);
    return (dst != '0) && (dst < DUP_OFS);
  endfunction

  function automatic logic is_dup(input logic [REG_SEL-1:0] dst);
    return dst > DUP_OFS;
  endfunction

  always_comb begin
    commit = cif.arfwe1 || cif.arfwe2;
    o1     = cif.arfwe1 && is_orig(cif.dstarf1);
    o2     = cif.arfwe2 && is_orig(cif.dstarf2);
    u1     = cif.arfwe1 && is_dup(cif.dstarf1);
    u2     = cif.arfwe2 && is_dup(cif.dstarf2);
    orig_d = orig_q + CNT_W'({1'b0, o1} + {1'b0, o2});
    dup_d  = dup_q + CNT_W'({1'b0, u1} + {1'b0, u2});

    // Port 2 is the younger commit, so its write lands last.
    shadow_d = shadow_q;
    if (cif.arfwe1 && cif.dstarf1 != '0) shadow_d[cif.dstarf1] = cif.wdata1;
    if (cif.arfwe2 && cif.dstarf2 != '0) shadow_d[cif.dstarf2] = cif.wdata2;
  end

  assign orig_sel   = REG_SEL'(idx_q);
  assign dup_sel    = orig_sel | DUP_OFS;
  assign pair_match = shadow_q[orig_sel] == shadow_q[dup_sel];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dirty_d    = dirty_q || o1 || o2 || u1 || u2;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (cif.ena && dirty_q && (orig_q == dup_q) && !commit) begin
          state_d = S_CHECK;
          idx_d   = 4'd1;
        end
      end
      S_CHECK: begin
        // A new commit invalidates the snapshot; drop out and wait for quiet.
        if (commit) begin
          state_d = S_IDLE;
        end else if (!pair_match) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          dirty_d = 1'b0;
          if (!fail_q) begin
            fail_d     = 1'b1;
            fail_idx_d = idx_q;
          end
        end else if (idx_q == 4'd15) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
          dirty_d = 1'b0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      dirty_q    <= 1'b0;
      orig_q     <= '0;
      dup_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      shadow_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dirty_q    <= dirty_d;
      orig_q     <= orig_d;
      dup_q      <= dup_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      shadow_q   <= shadow_d;
    end
  end

  assign cif.orig_cnt   = orig_q;
  assign cif.dup_cnt    = dup_q;
  assign cif.busy       = (state_q == S_CHECK);
  assign cif.check_done = done_q;
  assign cif.check_pass = pass_q;
  assign cif.qed_fail   = fail_q;
  assign cif.fail_idx   = fail_idx_q;
endmodule

// File: tb/tb_qed_commit_checker.sv
// Bench for qed_commit_checker: vector table plus per-cycle scoreboard on the
// main instance, and a narrow-counter instance for wrap and async reset.
module tb_qed_commit_checker;
  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  always #5 clk = ~clk;

  qed_commit_if mif ();
  qed_commit_if #(.CNT_W(4)) wif ();

  qed_commit_checker u_dut (.clk(clk), .rst(rst), .cif(mif.slave));
  qed_commit_checker #(.CNT_W(4)) u_wrap (.clk(clk), .rst(rst_w), .cif(wif.slave));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] orig;
    logic [15:0] dup;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [3:0]  fidx;
  } obs_t;

  obs_t sbq[$];

  typedef struct {
    bit          ena;
    bit          we1;
    logic [4:0]  d1;
    logic [31:0] w1;
    bit          we2;
    logic [4:0]  d2;
    logic [31:0] w2;
    int          rep;
    int          e_orig;
    int          e_dup;
    bit          e_busy;
    int          e_nd;
    int          e_np;
    bit          e_fail;
    int          e_idx;
  } vec_t;

  vec_t vecs[$];

  // Reference model: on trigger it scans the shadow once and schedules the end.
  logic [31:0] m_sh [32];
  int m_orig, m_dup, m_pos, m_end, m_fidx;
  bit m_dirty, m_busy, m_spass, m_done, m_pass, m_fail;
  int nd, np;

  function automatic vec_t mk(bit ena, bit we1, int d1, int w1, bit we2, int d2, int w2, int rep,
                              int eo, int ed, bit eb, int end_n, int enp, bit ef, int ei);
    vec_t v;
    v.ena = ena; v.we1 = we1; v.d1 = 5'(d1); v.w1 = 32'(w1);
    v.we2 = we2; v.d2 = 5'(d2); v.w2 = 32'(w2); v.rep = rep;
    v.e_orig = eo; v.e_dup = ed; v.e_busy = eb; v.e_nd = end_n; v.e_np = enp;
    v.e_fail = ef; v.e_idx = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_commit(input bit we, input logic [4:0] d, input logic [31:0] w);
    if (!we) return;
    if (d != 5'd0) m_sh[d] = w;
    if (d >= 5'd1 && d <= 5'd15) begin
      m_orig = (m_orig + 1) % 65536;
      m_dirty = 1'b1;
    end else if (d >= 5'd17) begin
      m_dup = (m_dup + 1) % 65536;
      m_dirty = 1'b1;
    end
  endtask

  task automatic model_step(input bit ena, input bit we1, input logic [4:0] d1, input logic [31:0] w1,
                            input bit we2, input logic [4:0] d2, input logic [31:0] w2);
    bit cm;
    cm = we1 || we2;
    m_done = 1'b0;
    if (m_busy) begin
      if (cm) begin
        m_busy = 1'b0;
      end else if (m_pos == m_end) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_pass = m_spass;
        m_dirty = 1'b0;
        if (!m_spass && !m_fail) begin
          m_fail = 1'b1;
          m_fidx = m_end;
        end
      end else begin
        m_pos++;
      end
    end else if (ena && m_dirty && m_orig == m_dup && !cm) begin
      m_busy = 1'b1;
      m_pos = 1;
      m_end = 15;
      m_spass = 1'b1;
      for (int k = 15; k >= 1; k--) begin
        if (m_sh[k] != m_sh[k+16]) begin
          m_end = k;
          m_spass = 1'b0;
        end
      end
    end
    model_commit(we1, d1, w1);
    model_commit(we2, d2, w2);
  endtask

  function automatic obs_t sample_main();
    return obs_t'({mif.orig_cnt, mif.dup_cnt, mif.busy, mif.check_done, mif.check_pass,
                   mif.qed_fail, mif.fail_idx});
  endfunction

  task automatic cycle(input bit ena, input bit we1, input logic [4:0] d1, input logic [31:0] w1,
                       input bit we2, input logic [4:0] d2, input logic [31:0] w2);
    obs_t got, exp;
    @(negedge clk);
    mif.ena = ena; mif.arfwe1 = we1; mif.dstarf1 = d1; mif.wdata1 = w1;
    mif.arfwe2 = we2; mif.dstarf2 = d2; mif.wdata2 = w2;
    model_step(ena, we1, d1, w1, we2, d2, w2);
    sbq.push_back(obs_t'({16'(m_orig), 16'(m_dup), m_busy, m_done, m_pass, m_fail, 4'(m_fidx)}));
    @(posedge clk);
    #1;
    got = sample_main();
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      exp = sbq.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t got orig=%0d dup=%0d busy=%0b done=%0b pass=%0b fail=%0b idx=%0d expected orig=%0d dup=%0d busy=%0b done=%0b pass=%0b fail=%0b idx=%0d",
                 $time, got.orig, got.dup, got.busy, got.done, got.pass, got.fail, got.fidx,
                 exp.orig, exp.dup, exp.busy, exp.done, exp.pass, exp.fail, exp.fidx);
      end
    end
    if (got.done) nd++;
    if (got.done && got.pass) np++;
  endtask

  task automatic wcycle(input bit we1, input int d1, input bit we2, input int d2);
    @(negedge clk);
    wif.ena = 1'b1;
    wif.arfwe1 = we1; wif.dstarf1 = 5'(d1); wif.wdata1 = 32'h42;
    wif.arfwe2 = we2; wif.dstarf2 = 5'(d2); wif.wdata2 = 32'h42;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    rst_w = 1'b1;
    mif.ena = 1'b0; mif.arfwe1 = 1'b0; mif.arfwe2 = 1'b0;
    mif.dstarf1 = '0; mif.dstarf2 = '0; mif.wdata1 = '0; mif.wdata2 = '0;
    wif.ena = 1'b0; wif.arfwe1 = 1'b0; wif.arfwe2 = 1'b0;
    wif.dstarf1 = '0; wif.dstarf2 = '0; wif.wdata1 = '0; wif.wdata2 = '0;
    for (int i = 0; i < 32; i++) m_sh[i] = '0;
    m_orig = 0; m_dup = 0; m_pos = 0; m_end = 0; m_fidx = 0;
    m_dirty = 0; m_busy = 0; m_spass = 0; m_done = 0; m_pass = 0; m_fail = 0;

    //        ena we1 d1  w1           we2 d2  w2    rep  orig dup busy nd np fail idx
    vecs.push_back(mk(1, 1, 5, 32'hA5A50001, 0, 0, 0, 1,    1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 21, 32'hA5A50001, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20,              1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 9, 1, 1, 9, 2, 1,               3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 25, 2, 0, 0, 0, 1,              3, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3,               3, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 25, 2, 1,              3, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20,              3, 3, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'h11, 1, 17, 32'h11, 1,    4, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 5,               4, 4, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'h11, 0, 0, 0, 1,          5, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3,               5, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 17, 32'h11, 0, 0, 0, 1,         5, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20,              5, 5, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h55, 1, 16, 32'h66, 3,    5, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20,              5, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 2, 1, 18, 2, 1,              6, 6, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 10,              6, 6, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20,              6, 6, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 7, 1, 19, 8, 1,              7, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20,              7, 7, 0, 1, 0, 1, 3));
    vecs.push_back(mk(1, 1, 3, 8, 1, 4, 1, 1,               9, 7, 0, 0, 0, 1, 3));
    vecs.push_back(mk(1, 1, 20, 5, 1, 22, 0, 1,             9, 9, 0, 0, 0, 1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20,              9, 9, 0, 1, 0, 1, 3));
    vecs.push_back(mk(1, 1, 20, 1, 1, 4, 1, 1,              10, 10, 0, 0, 0, 1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2,               10, 10, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 20,              10, 10, 0, 1, 1, 1, 3));

    repeat (2) @(posedge clk);
    #1;
    check("reset_main", 64'(sample_main()), 64'd0);
    check("reset_wrap_cnt", 64'({wif.orig_cnt, wif.dup_cnt, wif.busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rst_w = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      nd = 0;
      np = 0;
      for (int r = 0; r < v.rep; r++) cycle(v.ena, v.we1, v.d1, v.w1, v.we2, v.d2, v.w2);
      check($sformatf("vec%0d_state", i),
            64'({mif.orig_cnt, mif.dup_cnt, mif.busy, mif.qed_fail, mif.fail_idx}),
            64'({16'(v.e_orig), 16'(v.e_dup), v.e_busy, v.e_fail, 4'(v.e_idx)}));
      check($sformatf("vec%0d_done_count", i), 64'(nd), 64'(v.e_nd));
      check($sformatf("vec%0d_pass_count", i), 64'(np), 64'(v.e_np));
    end

    // Narrow-counter instance: climb to 15/15, wrap both to 1/1, then reset mid-sweep.
    for (int i = 0; i < 7; i++) wcycle(1, 1, 1, 1);
    wcycle(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) wcycle(1, 17, 1, 17);
    wcycle(1, 17, 0, 0);
    check("wrap_preset", 64'({wif.orig_cnt, wif.dup_cnt, wif.busy}), 64'({4'hF, 4'hF, 1'b0}));
    wcycle(1, 1, 1, 17);
    check("wrap_zero", 64'({wif.orig_cnt, wif.dup_cnt}), 64'({4'h0, 4'h0}));
    wcycle(1, 1, 1, 17);
    check("wrap_one", 64'({wif.orig_cnt, wif.dup_cnt, wif.busy}), 64'({4'h1, 4'h1, 1'b0}));
    wcycle(0, 0, 0, 0);
    check("wrap_sweep_start", 64'(wif.busy), 64'd1);
    repeat (3) wcycle(0, 0, 0, 0);
    check("wrap_sweep_running", 64'({wif.busy, wif.check_done}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    #2;
    rst_w = 1'b1;
    #1;
    check("async_reset_mid_sweep",
          64'({wif.orig_cnt, wif.dup_cnt, wif.busy, wif.check_done, wif.check_pass,
               wif.qed_fail, wif.fail_idx}), 64'd0);
    @(negedge clk);
    rst_w = 1'b0;
    repeat (3) wcycle(0, 0, 0, 0);
    check("post_reset_idle", 64'({wif.orig_cnt, wif.dup_cnt, wif.busy}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
